axis_ram_frame_reader: RTL and testbench

- Drains one buffered Ethernet frame from the wide read port of the asymmetric frame RAM and serialises it onto a narrow AXI-Stream master.
- Sits directly downstream of the frame RAM; it consumes the RAM's registered wide-read data.
- Per frame: takes a descriptor (start word address and length in narrow beats), issues wide reads, splits each word into lanes, and emits lanes with tlast on the final beat.
- Two-word buffering sustains 1 beat/cycle under continuous tready.

---
 rtl/axis_ram_frame_reader.sv | 159 +++++++++++++++
 tb/tb_axis_ram_frame_reader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_ram_frame_reader.sv
// axis_ram_frame_reader: drains one buffered frame from the wide RAM read port
// and serialises it onto a narrow AXI-Stream master, lane 0 first. Two word
// slots (cur, nxt) plus one in-flight read keep the stream at one beat per cycle.
module axis_ram_frame_reader #(
    parameter int DATA_W = 8,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              desc_valid,
    output logic              desc_ready,
    input  logic [ADDR_W-1:0] desc_addr,
    input  logic [LEN_W-1:0]  desc_len,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [WORD_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy
);
    localparam int RATIO   = WORD_W / DATA_W;
    localparam int LANE_SH = $clog2(RATIO);
    localparam int LANE_W  = (RATIO > 1) ? LANE_SH : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [LEN_W-1:0]  beats_left_reg;
    logic [LEN_W-1:0]  words_left_reg;
    logic              pending_reg;
    logic [WORD_W-1:0] cur_reg;
    logic [WORD_W-1:0] nxt_reg;
    logic              cur_valid_reg;
    logic              nxt_valid_reg;
    logic [LANE_W-1:0] lane_reg;

    logic [DATA_W-1:0] lanes [RATIO];
    logic [LEN_W:0]    len_round;
    logic              fire;
    logic              cur_last_lane;
    logic              cur_done;
    logic [2:0]        slots_used;
    logic              issue;

    // Split the current word into narrow lanes; lane 0 is the least significant.
    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_lane
            assign lanes[gi] = cur_reg[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign len_round     = {1'b0, desc_len} + (LEN_W+1)'(RATIO - 1);
    assign fire          = m_axis_tvalid && m_axis_tready;
    // The word is finished on its top lane, or early on the frame's final beat.
    assign cur_last_lane = (lane_reg == LANE_W'(RATIO - 1)) || (beats_left_reg == LEN_W'(1));
    assign cur_done      = fire && cur_last_lane;
    // Words that will occupy a slot after this edge; a new read is only
    // allowed if its data is guaranteed a slot on return.
    assign slots_used    = 3'(cur_valid_reg) + 3'(nxt_valid_reg) + 3'(pending_reg) - 3'(cur_done);
    assign issue         = (state_reg == ST_RUN) && (words_left_reg != '0) && (slots_used < 3'd2);

    assign ram_en        = issue;
    assign ram_addr      = addr_reg;
    assign desc_ready    = (state_reg == ST_IDLE);
    assign busy          = (state_reg != ST_IDLE);
    assign m_axis_tvalid = (state_reg == ST_RUN) && cur_valid_reg;
    assign m_axis_tdata  = lanes[lane_reg];
    assign m_axis_tlast  = m_axis_tvalid && (beats_left_reg == LEN_W'(1));

    // Frame sequencing, read issue, word capture and lane stepping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            beats_left_reg <= '0;
            words_left_reg <= '0;
            pending_reg    <= 1'b0;
            cur_reg        <= '0;
            nxt_reg        <= '0;
            cur_valid_reg  <= 1'b0;
            nxt_valid_reg  <= 1'b0;
            lane_reg       <= '0;
        end else begin
            pending_reg <= issue;
            case (state_reg)
                ST_IDLE: begin
                    if (desc_valid) begin
                        addr_reg       <= desc_addr;
                        beats_left_reg <= desc_len;
                        words_left_reg <= LEN_W'(len_round >> LANE_SH);
                        cur_valid_reg  <= 1'b0;
                        nxt_valid_reg  <= 1'b0;
                        lane_reg       <= '0;
                        state_reg      <= (desc_len == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        addr_reg       <= addr_reg + ADDR_W'(1);
                        words_left_reg <= words_left_reg - LEN_W'(1);
                    end
                    if (fire) begin
                        beats_left_reg <= beats_left_reg - LEN_W'(1);
                    end
                    if (cur_done) begin
                        // Retire cur: promote nxt first so word order is kept.
                        lane_reg <= '0;
                        if (nxt_valid_reg) begin
                            cur_reg <= nxt_reg;
                            if (pending_reg) begin
                                nxt_reg <= ram_rdata;
                            end else begin
                                nxt_valid_reg <= 1'b0;
                            end
                        end else if (pending_reg) begin
                            cur_reg <= ram_rdata;
                        end else begin
                            cur_valid_reg <= 1'b0;
                        end
                    end else begin
                        if (fire) begin
                            lane_reg <= lane_reg + LANE_W'(1);
                        end
                        if (pending_reg) begin
                            if (!cur_valid_reg) begin
                                cur_reg       <= ram_rdata;
                                cur_valid_reg <= 1'b1;
                                lane_reg      <= '0;
                            end else begin
                                nxt_reg       <= ram_rdata;
                                nxt_valid_reg <= 1'b1;
                            end
                        end
                    end
                    if (fire && (beats_left_reg == LEN_W'(1))) begin
                        // Unused lanes of a partial final word are dropped here.
                        cur_valid_reg <= 1'b0;
                        nxt_valid_reg <= 1'b0;
                        state_reg     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axis_ram_frame_reader.sv
// Bench for axis_ram_frame_reader: a RAM model with registered read, a queue
// model of expected beats and read addresses, and a per-cycle compare process.
module tb_axis_ram_frame_reader;
    localparam int DATA_W = 8;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 8;
    localparam int LEN_W  = 12;
    localparam int RATIO  = WORD_W / DATA_W;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              l;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              desc_valid;
    logic              desc_ready;
    logic [ADDR_W-1:0] desc_addr;
    logic [LEN_W-1:0]  desc_len;
    logic              ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [WORD_W-1:0] ram_rdata = '0;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b1;
    logic              m_axis_tlast;
    logic              busy;

    axis_ram_frame_reader #(
        .DATA_W(DATA_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_addr(desc_addr), .desc_len(desc_len),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .busy(busy)
    );

    logic [WORD_W-1:0] mem [256];
    always @(posedge clk) if (ram_en) ram_rdata <= mem[ram_addr];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    beat_t             exp_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [DATA_W-1:0] got_d[$];
    logic              got_l[$];
    logic [ADDR_W-1:0] got_a[$];
    int    reads, beats_done, first_en, first_v, last_v, t_acc;
    bit    mon_en = 1'b0;
    int    rdy_mode = 0;
    logic  prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_d;
    logic  prev_l;
    beat_t e_mon;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Ready pattern: 0 = always ready, 1 = low on odd cycles, 2 = random.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = (cyc % 2 == 0);
            default: m_axis_tready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Compare process: checks reads, beats, holds and occupancy every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ram_en) begin
                if (first_en < 0) first_en = cyc;
                got_a.push_back(ram_addr);
                reads++;
                if (exp_addr_q.size() == 0) check("ram_en_unexpected", 1, 0);
                else check("ram_addr", ram_addr, exp_addr_q.pop_front());
            end
            if (prev_stall) begin
                check("hold_valid", m_axis_tvalid, 1);
                check("hold_data", m_axis_tdata, prev_d);
                check("hold_last", m_axis_tlast, prev_l);
            end
            if (m_axis_tvalid) begin
                if (first_v < 0) first_v = cyc;
                if (m_axis_tready) begin
                    beats_done++;
                    last_v = cyc;
                    got_d.push_back(m_axis_tdata);
                    got_l.push_back(m_axis_tlast);
                    if (exp_q.size() == 0) check("beat_unexpected", 1, 0);
                    else begin
                        e_mon = exp_q.pop_front();
                        check("beat_data", m_axis_tdata, e_mon.d);
                        check("beat_last", m_axis_tlast, e_mon.l);
                    end
                end
            end else begin
                check("idle_last", m_axis_tlast, 0);
            end
            check("outstanding_le2", (reads - beats_done / RATIO) > 2, 0);
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_d     = m_axis_tdata;
            prev_l     = m_axis_tlast;
        end
    end

    // Present one descriptor and load the model with what it must produce.
    task automatic start_frame(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] n);
        int w;
        logic [WORD_W-1:0] word;
        beat_t b;
        w = 0;
        while (!desc_ready && w < 10) begin
            @(posedge clk); #1; w++;
        end
        check("desc_ready_wait", desc_ready, 1);
        reads = 0; beats_done = 0; first_en = -1; first_v = -1; last_v = -1;
        got_d.delete(); got_l.delete(); got_a.delete();
        for (int i = 0; i < int'(n); i++) begin
            word = mem[(int'(a) + i / RATIO) % 256];
            b.d  = word[(i % RATIO)*DATA_W +: DATA_W];
            b.l  = (i == int'(n) - 1);
            exp_q.push_back(b);
        end
        for (int k = 0; k < (int'(n) + RATIO - 1) / RATIO; k++)
            exp_addr_q.push_back(ADDR_W'((int'(a) + k) % 256));
        desc_valid = 1'b1; desc_addr = a; desc_len = n; t_acc = cyc;
        @(posedge clk); #1;
        desc_valid = 1'b0;
    endtask

    task automatic finish_frame();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || busy) && w < 400) begin
            @(posedge clk); #1; w++;
        end
        check("frame_timeout", w < 400, 1);
        check("reads_left", exp_addr_q.size(), 0);
    endtask

    logic [DATA_W-1:0] lit [8];
    int w0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[8'h10] = 32'h44332211;
        mem[8'h11] = 32'h88776655;
        mem[8'hFF] = 32'hA4A3A2A1;
        mem[8'h00] = 32'hB4B3B2B1;
        lit = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        rst_n = 1'b0; desc_valid = 1'b0; desc_addr = '0; desc_len = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_desc_ready", desc_ready, 1);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1; mon_en = 1'b1;
        @(posedge clk); #1;

        // Basic frame, two full words, continuous ready.
        start_frame(8'h10, 12'd8);
        finish_frame();
        check("t1_count", got_d.size(), 8);
        for (int i = 0; i < 8 && i < got_d.size(); i++) begin
            check("t1_data", got_d[i], lit[i]);
            check("t1_last", got_l[i], (i == 7));
        end
        check("t1_reads", got_a.size(), 2);
        if (got_a.size() == 2) begin
            check("t1_addr0", got_a[0], 8'h10);
            check("t1_addr1", got_a[1], 8'h11);
        end
        check("t1_first_en", first_en - t_acc, 1);
        check("t1_first_v", first_v - t_acc, 3);
        check("t1_back_to_back", last_v - first_v, 7);

        // Partial final word.
        start_frame(8'h10, 12'd6);
        finish_frame();
        check("t2_count", got_d.size(), 6);
        if (got_d.size() == 6) begin
            check("t2_last_data", got_d[5], 8'h66);
            check("t2_last_flag", got_l[5], 1);
        end

        // Backpressure on every odd cycle.
        rdy_mode = 1;
        start_frame(8'h10, 12'd8);
        finish_frame();
        check("t3_count", got_d.size(), 8);
        for (int i = 0; i < 8 && i < got_d.size(); i++) check("t3_data", got_d[i], lit[i]);
        rdy_mode = 0;

        // Address wrap.
        start_frame(8'hFF, 12'd8);
        finish_frame();
        check("t4_reads", got_a.size(), 2);
        if (got_a.size() == 2) begin
            check("t4_addr0", got_a[0], 8'hFF);
            check("t4_addr1", got_a[1], 8'h00);
        end
        if (got_d.size() == 8) begin
            check("t4_lane3", got_d[3], 8'hA4);
            check("t4_lane4", got_d[4], 8'hB1);
        end

        // Zero-length descriptor.
        start_frame(8'h20, 12'd0);
        check("t5_ready_low", desc_ready, 0);
        check("t5_busy", busy, 1);
        w0 = 0;
        while (!desc_ready && w0 < 5) begin
            @(posedge clk); #1; w0++;
        end
        check("t5_gap", (w0 >= 1) && (w0 <= 2), 1);
        repeat (3) @(posedge clk);
        #1;
        check("t5_no_reads", got_a.size(), 0);
        check("t5_no_beats", first_v, 32'hFFFFFFFF);

        // Reset in the middle of a frame.
        start_frame(8'h10, 12'd8);
        w0 = 0;
        while (beats_done < 3 && w0 < 50) begin
            @(posedge clk); #1; w0++;
        end
        check("t6_reach_beat3", beats_done, 3);
        rst_n = 1'b0; mon_en = 1'b0;
        exp_q.delete(); exp_addr_q.delete();
        @(posedge clk); #1;
        check("t6_tvalid", m_axis_tvalid, 0);
        check("t6_tlast", m_axis_tlast, 0);
        check("t6_ram_en", ram_en, 0);
        check("t6_desc_ready", desc_ready, 1);
        rst_n = 1'b1; prev_stall = 1'b0; mon_en = 1'b1;
        @(posedge clk); #1;
        start_frame(8'h10, 12'd8);
        finish_frame();
        check("t6_count", got_d.size(), 8);
        if (got_d.size() == 8) check("t6_first", got_d[0], 8'h11);

        // Randomised frames with random backpressure.
        rdy_mode = 2;
        for (int f = 0; f < 30; f++) begin
            start_frame(ADDR_W'($urandom_range(0, 255)), LEN_W'($urandom_range(0, 22)));
            finish_frame();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        bad++;
        $display("FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
